// File: rtl/kf_bus_master_arbiter.sv
// Multi-master bus arbiter for the PC/XT core: takes the 8088 off the bus with the
// hold handshake, then grants the bus to one requester (fixed or rotating priority).
module kf_bus_master_arbiter #(
    parameter int NUM_MASTERS     = 4,
    parameter int ROTATING        = 0,
    parameter int MAX_HOLD_CYCLES = 64,
    parameter int CW              = 7
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   cpu_clock,
    input  logic [2:0]             processor_status,
    input  logic                   processor_lock_n,
    input  logic [NUM_MASTERS-1:0] request,
    output logic [NUM_MASTERS-1:0] grant,
    output logic [2:0]             owner_index,
    output logic                   address_enable_n,
    output logic                   dma_wait_n,
    output logic                   hold_acknowledge,
    output logic                   hold_timeout,
    output logic [2:0]             debug_state
);
    localparam int IW = $clog2(NUM_MASTERS);

    // Request/grant handshake: a master raises request and holds it for as long
    // as it wants the bus. grant rises only after the CPU drivers are off
    // (address_enable_n=1) and falls on the clock request[owner] is seen low or
    // the hold limit expires; the master must stop driving once grant is low.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SYNC  = 3'd1,
        ST_HLDA  = 3'd2,
        ST_AEN   = 3'd3,
        ST_GRANT = 3'd4,
        ST_REL   = 3'd5
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic                   prev_cpu_clock;
    logic                   cpu_pos;
    logic                   cpu_neg;
    logic                   hold_req;
    logic                   bus_idle_status;
    logic                   status_unused;
    logic                   owner_requesting;
    logic                   limit_hit;
    logic [IW-1:0]          owner;
    logic [IW-1:0]          owner_next;
    logic [IW-1:0]          rr_ptr;
    logic [IW-1:0]          rr_next;
    logic [CW-1:0]          count;
    logic [CW-1:0]          count_next;
    logic [NUM_MASTERS-1:0] grant_next;
    logic                   aen_next;
    logic                   wait_next;
    logic                   hlda_next;
    logic                   timeout_next;
    logic                   win_found;
    logic [IW-1:0]          win_index;
    logic [IW:0]            win_base;
    logic [IW:0]            win_slot;

    assign cpu_pos         = ~prev_cpu_clock & cpu_clock;
    assign cpu_neg         = prev_cpu_clock & ~cpu_clock;
    assign hold_req        = |request;
    // S1=S0=1 is passive or halt; S2 only separates those two, both allow takeover.
    assign bus_idle_status = processor_status[1] & processor_status[0];
    assign status_unused   = processor_status[2];
    assign owner_requesting = request[owner];
    assign limit_hit       = (MAX_HOLD_CYCLES != 0) && (count == CW'(MAX_HOLD_CYCLES));

    // Priority search: from index 0 in fixed mode, from rr_ptr upward (wrapping) otherwise.
    always_comb begin
        win_found = 1'b0;
        win_index = '0;
        win_base  = (ROTATING != 0) ? {1'b0, rr_ptr} : '0;
        win_slot  = '0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            win_slot = win_base + (IW+1)'(k);
            if (win_slot >= (IW+1)'(NUM_MASTERS)) begin
                win_slot = win_slot - (IW+1)'(NUM_MASTERS);
            end
            if (!win_found && request[win_slot[IW-1:0]]) begin
                win_found = 1'b1;
                win_index = win_slot[IW-1:0];
            end
        end
    end

    always_comb begin
        state_next   = state;
        grant_next   = grant;
        owner_next   = owner;
        aen_next     = address_enable_n;
        wait_next    = dma_wait_n;
        hlda_next    = hold_acknowledge;
        timeout_next = 1'b0;
        rr_next      = rr_ptr;
        count_next   = count;
        case (state)
            ST_IDLE: begin
                if (cpu_pos && hold_req && bus_idle_status && processor_lock_n) begin
                    state_next = ST_SYNC;
                end
            end
            ST_SYNC: begin
                if (cpu_neg) begin
                    if (hold_req) begin
                        state_next = ST_HLDA;
                        hlda_next  = 1'b1;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end
            ST_HLDA: begin
                if (cpu_pos) begin
                    if (hold_req) begin
                        state_next = ST_AEN;
                        aen_next   = 1'b1;
                    end else begin
                        state_next = ST_IDLE;
                        hlda_next  = 1'b0;
                    end
                end
            end
            ST_AEN: begin
                if (cpu_pos) begin
                    if (hold_req) begin
                        state_next = ST_GRANT;
                        owner_next = win_index;
                        grant_next = {{(NUM_MASTERS-1){1'b0}}, 1'b1} << win_index;
                        wait_next  = 1'b0;
                    end else begin
                        state_next = ST_REL;
                    end
                end
            end
            ST_GRANT: begin
                // Release and limit are checked every clock; the limit wins the pulse even if request also fell.
                if (!owner_requesting || limit_hit) begin
                    state_next   = ST_REL;
                    grant_next   = '0;
                    wait_next    = 1'b1;
                    timeout_next = limit_hit;
                    rr_next      = (owner == IW'(NUM_MASTERS - 1)) ? '0 : owner + IW'(1);
                end else if (cpu_pos) begin
                    count_next = count + CW'(1);
                end
            end
            ST_REL: begin
                wait_next = 1'b1;
                if (cpu_pos) begin
                    state_next = ST_IDLE;
                    aen_next   = 1'b0;
                    hlda_next  = 1'b0;
                    count_next = '0;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state            <= ST_IDLE;
            prev_cpu_clock   <= 1'b0;
            grant            <= '0;
            owner            <= '0;
            address_enable_n <= 1'b0;
            dma_wait_n       <= 1'b1;
            hold_acknowledge <= 1'b0;
            hold_timeout     <= 1'b0;
            rr_ptr           <= '0;
            count            <= '0;
        end else begin
            state            <= state_next;
            prev_cpu_clock   <= cpu_clock;
            grant            <= grant_next;
            owner            <= owner_next;
            address_enable_n <= aen_next;
            dma_wait_n       <= wait_next;
            hold_acknowledge <= hlda_next;
            hold_timeout     <= timeout_next;
            rr_ptr           <= rr_next;
            count            <= count_next;
        end
    end

    assign owner_index = 3'(owner);
    assign debug_state = state;

endmodule

// File: tb/tb_kf_bus_master_arbiter.sv
// Bench for kf_bus_master_arbiter: a fixed-priority instance with an 8-cycle hold limit
// and a rotating instance with the default limit, both checked against a behavioural model.
module tb_kf_bus_master_arbiter;
    localparam int P_IDLE  = 0;
    localparam int P_SYNC  = 1;
    localparam int P_HLDA  = 2;
    localparam int P_AEN   = 3;
    localparam int P_GRANT = 4;
    localparam int P_REL   = 5;

    logic       clock;
    logic       reset;
    logic       cpu_clock;
    logic [2:0] status;
    logic       lock_n;
    logic [3:0] request;

    logic [3:0] f_grant, r_grant;
    logic [2:0] f_owner, r_owner, f_dbg, r_dbg;
    logic       f_aen_n, f_wait_n, f_hlda, f_tmo;
    logic       r_aen_n, r_wait_n, r_hlda, r_tmo;

    int n_vec = 0;
    int n_miss = 0;
    int cpu_pos_seen = 0;
    logic tb_prev = 1'b0;

    // model state, index 0 = fixed/limit 8, index 1 = rotating/limit 64
    int   m_ph [2];
    logic [3:0] m_grant [2];
    int   m_owner [2];
    logic m_aen_n [2], m_wait_n [2], m_hlda [2], m_tmo [2], m_prev [2];
    int   m_rr [2], m_cnt [2];

    logic [3:0] exp_q[$];
    logic [3:0] r_grant_prev = 4'b0000;

    logic [3:0] t2_req [4] = '{4'b0010, 4'b1010, 4'b1111, 4'b1111};
    logic [3:0] t2_fix [4] = '{4'b0010, 4'b0010, 4'b0001, 4'b0001};
    logic [3:0] t2_rot [4] = '{4'b0010, 4'b1000, 4'b0001, 4'b0010};
    int         t2_fown [4] = '{1, 1, 0, 0};
    int         t2_rown [4] = '{1, 3, 0, 1};

    kf_bus_master_arbiter #(.NUM_MASTERS(4), .ROTATING(0), .MAX_HOLD_CYCLES(8), .CW(4)) u_fix (
        .clock(clock), .reset(reset), .cpu_clock(cpu_clock),
        .processor_status(status), .processor_lock_n(lock_n), .request(request),
        .grant(f_grant), .owner_index(f_owner), .address_enable_n(f_aen_n),
        .dma_wait_n(f_wait_n), .hold_acknowledge(f_hlda), .hold_timeout(f_tmo),
        .debug_state(f_dbg)
    );

    kf_bus_master_arbiter #(.NUM_MASTERS(4), .ROTATING(1), .MAX_HOLD_CYCLES(64), .CW(7)) u_rot (
        .clock(clock), .reset(reset), .cpu_clock(cpu_clock),
        .processor_status(status), .processor_lock_n(lock_n), .request(request),
        .grant(r_grant), .owner_index(r_owner), .address_enable_n(r_aen_n),
        .dma_wait_n(r_wait_n), .hold_acknowledge(r_hlda), .hold_timeout(r_tmo),
        .debug_state(r_dbg)
    );

    // clock / reset block
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        cpu_clock = 1'b0;
        forever begin
            repeat (2) @(negedge clock);
            cpu_clock = ~cpu_clock;
        end
    end

    initial begin
        forever begin
            @(posedge clock);
            if (cpu_clock && !tb_prev) cpu_pos_seen++;
            tb_prev = cpu_clock;
        end
    end

    task automatic check(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s inst%0d: actual %0h, required %0h at %0t", name, inst, act, exp, $time);
        end
    endtask

    function automatic int pick(input int i);
        int base;
        int idx;
        base = (i == 1) ? m_rr[1] : 0;
        for (int k = 0; k < 4; k++) begin
            idx = (base + k) % 4;
            if (((request >> idx) & 4'b0001) != 4'b0000) return idx;
        end
        return 0;
    endfunction

    task automatic model_step(input int i);
        bit pos;
        bit neg;
        bit any;
        bit lim_hit;
        int lim;
        int w;
        lim = (i == 0) ? 8 : 64;
        if (reset) begin
            m_ph[i] = P_IDLE; m_grant[i] = 4'b0000; m_owner[i] = 0;
            m_aen_n[i] = 1'b0; m_wait_n[i] = 1'b1; m_hlda[i] = 1'b0; m_tmo[i] = 1'b0;
            m_prev[i] = 1'b0; m_rr[i] = 0; m_cnt[i] = 0;
            return;
        end
        pos = cpu_clock && !m_prev[i];
        neg = !cpu_clock && m_prev[i];
        m_prev[i] = cpu_clock;
        any = (request != 4'b0000);
        m_tmo[i] = 1'b0;
        case (m_ph[i])
            P_IDLE: if (pos && any && status[1] && status[0] && lock_n) m_ph[i] = P_SYNC;
            P_SYNC: if (neg) begin
                if (any) begin m_ph[i] = P_HLDA; m_hlda[i] = 1'b1; end
                else m_ph[i] = P_IDLE;
            end
            P_HLDA: if (pos) begin
                if (any) begin m_ph[i] = P_AEN; m_aen_n[i] = 1'b1; end
                else begin m_ph[i] = P_IDLE; m_hlda[i] = 1'b0; end
            end
            P_AEN: if (pos) begin
                if (any) begin
                    w = pick(i);
                    m_owner[i] = w;
                    m_grant[i] = 4'b0001 << w;
                    m_wait_n[i] = 1'b0;
                    m_ph[i] = P_GRANT;
                end else m_ph[i] = P_REL;
            end
            P_GRANT: begin
                lim_hit = (lim != 0) && (m_cnt[i] == lim);
                if ((((request >> m_owner[i]) & 4'b0001) == 4'b0000) || lim_hit) begin
                    m_tmo[i] = lim_hit;
                    m_grant[i] = 4'b0000;
                    m_wait_n[i] = 1'b1;
                    m_rr[i] = (m_owner[i] + 1) % 4;
                    m_ph[i] = P_REL;
                end else if (pos) m_cnt[i]++;
            end
            default: begin
                m_wait_n[i] = 1'b1;
                if (pos) begin
                    m_aen_n[i] = 1'b0; m_hlda[i] = 1'b0; m_cnt[i] = 0; m_ph[i] = P_IDLE;
                end
            end
        endcase
    endtask

    task automatic cmp_inst(input int i);
        logic [3:0] g;
        logic [2:0] o;
        logic a, w, h, t;
        if (i == 0) begin g = f_grant; o = f_owner; a = f_aen_n; w = f_wait_n; h = f_hlda; t = f_tmo; end
        else begin g = r_grant; o = r_owner; a = r_aen_n; w = r_wait_n; h = r_hlda; t = r_tmo; end
        check("grant", i, 32'(g), 32'(m_grant[i]));
        check("address_enable_n", i, 32'(a), 32'(m_aen_n[i]));
        check("dma_wait_n", i, 32'(w), 32'(m_wait_n[i]));
        check("hold_acknowledge", i, 32'(h), 32'(m_hlda[i]));
        check("hold_timeout", i, 32'(t), 32'(m_tmo[i]));
        if (m_grant[i] != 4'b0000) check("owner_index", i, 32'(o), 32'(m_owner[i]));
    endtask

    // model update and per-cycle compare
    initial begin
        forever begin
            @(posedge clock);
            model_step(0);
            model_step(1);
            #1;
            cmp_inst(0);
            cmp_inst(1);
        end
    end

    // scoreboard: every new grant of the rotating instance must match the next expected one
    initial begin
        logic [3:0] e;
        forever begin
            @(posedge clock);
            #1;
            if (r_grant != 4'b0000 && r_grant_prev == 4'b0000) begin
                if (exp_q.size() == 0) check("rot_grant_extra", 1, 32'(r_grant), 32'd0);
                else begin
                    e = exp_q.pop_front();
                    check("rot_grant_order", 1, 32'(r_grant), 32'(e));
                end
            end
            r_grant_prev = r_grant;
        end
    end

    // driver tasks
    task automatic wait_fix_grant(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 80; c++) begin
            @(posedge clock);
            #1;
            if (f_grant != 4'b0000) begin ok = 1'b1; break; end
        end
    endtask

    task automatic release_all(input string name);
        bit ok;
        @(negedge clock);
        request = 4'b0000;
        ok = 1'b0;
        for (int c = 0; c < 60; c++) begin
            @(posedge clock);
            #1;
            if (!f_aen_n && !r_aen_n && !f_hlda && !r_hlda) begin ok = 1'b1; break; end
        end
        check(name, 2, 32'(ok), 32'd1);
        repeat (2) @(negedge clock);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout, required completion");
        n_miss++;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        bit dropped;
        bit seen_idle;
        bit regrant;
        int start;
        int tmo_cycles;
        int hl;

        reset = 1'b1; status = 3'b111; lock_n = 1'b1; request = 4'b0000;
        repeat (3) @(negedge clock);
        check("rst_grant", 0, 32'(f_grant), 32'd0);
        check("rst_grant", 1, 32'(r_grant), 32'd0);
        check("rst_aen_n", 0, 32'(f_aen_n), 32'd0);
        check("rst_wait_n", 0, 32'(f_wait_n), 32'd1);
        check("rst_hlda", 1, 32'(r_hlda), 32'd0);
        check("rst_tmo", 1, 32'(r_tmo), 32'd0);
        reset = 1'b0;
        repeat (8) @(negedge clock);

        // basic takeover and release
        request = 4'b0100;
        start = cpu_pos_seen;
        exp_q.push_back(4'b0100);
        wait_fix_grant(ok);
        check("t1_grant_seen", 0, 32'(ok), 32'd1);
        check("t1_pos_to_grant", 0, 32'(cpu_pos_seen - start), 32'd3);
        check("t1_grant", 0, 32'(f_grant), 32'b0100);
        check("t1_owner", 0, 32'(f_owner), 32'd2);
        check("t1_grant", 1, 32'(r_grant), 32'b0100);
        repeat (3) @(negedge clock);
        request = 4'b0000;
        @(posedge clock);
        #1;
        check("t1_drop_grant", 0, 32'(f_grant), 32'd0);
        check("t1_drop_grant", 1, 32'(r_grant), 32'd0);
        check("t1_aen_held", 0, 32'(f_aen_n), 32'd1);
        release_all("t1_release");

        // priority: fixed vs rotating
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            request = t2_req[k];
            exp_q.push_back(t2_rot[k]);
            wait_fix_grant(ok);
            check("t2_grant_seen", k, 32'(ok), 32'd1);
            check("t2_fix_grant", k, 32'(f_grant), 32'(t2_fix[k]));
            check("t2_rot_grant", k, 32'(r_grant), 32'(t2_rot[k]));
            check("t2_fix_owner", k, 32'(f_owner), 32'(t2_fown[k]));
            check("t2_rot_owner", k, 32'(r_owner), 32'(t2_rown[k]));
            release_all("t2_release");
        end

        // LOCK holds the arbiter in IDLE
        @(negedge clock);
        lock_n = 1'b0;
        request = 4'b0001;
        exp_q.push_back(4'b0001);
        repeat (40) @(negedge clock);
        check("t3_locked_aen", 0, 32'(f_aen_n), 32'd0);
        check("t3_locked_aen", 1, 32'(r_aen_n), 32'd0);
        check("t3_locked_hlda", 0, 32'(f_hlda), 32'd0);
        check("t3_locked_grant", 1, 32'(r_grant), 32'd0);
        lock_n = 1'b1;
        start = cpu_pos_seen;
        wait_fix_grant(ok);
        check("t3_grant_seen", 0, 32'(ok), 32'd1);
        check("t3_within_3_edges", 0, 32'((cpu_pos_seen - start) <= 3), 32'd1);
        check("t3_grant", 0, 32'(f_grant), 32'b0001);
        release_all("t3_release");

        // hold limit on the fixed instance, re-grant through IDLE
        @(negedge clock);
        request = 4'b0100;
        exp_q.push_back(4'b0100);
        wait_fix_grant(ok);
        check("t4_grant_seen", 0, 32'(ok), 32'd1);
        start = cpu_pos_seen;
        tmo_cycles = 0;
        dropped = 1'b0;
        for (int c = 0; c < 120; c++) begin
            @(posedge clock);
            #1;
            if (f_tmo) tmo_cycles++;
            if (f_grant == 4'b0000) begin dropped = 1'b1; break; end
        end
        check("t4_revoked", 0, 32'(dropped), 32'd1);
        check("t4_hold_len", 0, 32'(cpu_pos_seen - start), 32'd8);
        check("t4_rot_unlimited", 1, 32'(r_grant), 32'b0100);
        seen_idle = 1'b0;
        regrant = 1'b0;
        for (int c = 0; c < 120; c++) begin
            @(posedge clock);
            #1;
            if (f_tmo) tmo_cycles++;
            if (!f_aen_n) seen_idle = 1'b1;
            if (f_grant != 4'b0000) begin regrant = 1'b1; break; end
        end
        check("t4_regrant", 0, 32'(regrant), 32'd1);
        check("t4_via_idle", 0, 32'(seen_idle), 32'd1);
        check("t4_regrant_value", 0, 32'(f_grant), 32'b0100);
        check("t4_timeout_pulses", 0, 32'(tmo_cycles), 32'd1);
        release_all("t4_release");

        // code fetch status blocks SYNC; request dropped in SYNC never reaches HLDA
        @(negedge clock);
        status = 3'b100;
        request = 4'b0001;
        repeat (20) @(negedge clock);
        check("t5_fetch_aen", 0, 32'(f_aen_n), 32'd0);
        check("t5_fetch_hlda", 1, 32'(r_hlda), 32'd0);
        status = 3'b111;
        start = cpu_pos_seen;
        ok = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clock);
            #1;
            if (cpu_pos_seen != start) begin ok = 1'b1; break; end
        end
        check("t5_cpu_edge", 0, 32'(ok), 32'd1);
        @(negedge clock);
        request = 4'b0000;
        hl = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clock);
            #1;
            if (f_hlda || r_hlda) hl++;
        end
        check("t5_no_hlda", 2, 32'(hl), 32'd0);
        check("t5_aen_idle", 0, 32'(f_aen_n), 32'd0);

        // reset in the middle of a grant
        @(negedge clock);
        request = 4'b0001;
        exp_q.push_back(4'b0001);
        wait_fix_grant(ok);
        check("t6_grant_seen", 0, 32'(ok), 32'd1);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        check("t6_grant", 0, 32'(f_grant), 32'd0);
        check("t6_grant", 1, 32'(r_grant), 32'd0);
        check("t6_aen_n", 0, 32'(f_aen_n), 32'd0);
        check("t6_aen_n", 1, 32'(r_aen_n), 32'd0);
        check("t6_wait_n", 0, 32'(f_wait_n), 32'd1);
        check("t6_wait_n", 1, 32'(r_wait_n), 32'd1);
        check("t6_hlda", 0, 32'(f_hlda), 32'd0);
        check("t6_hlda", 1, 32'(r_hlda), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        request = 4'b0000;
        repeat (8) @(negedge clock);

        check("exp_q_empty", 1, 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
